// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: default sizes, output register states and the
// binary/Gray pointer conversions used by both the read and write controllers.
package fifo_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int ADDR_SIZE_DEF = 6;

    // Widest pointer the conversion helpers handle; callers cast to their width.
    localparam int PTR_W_MAX = 32;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray);
        logic [PTR_W_MAX-1:0] bin;
        bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// One-entry valid/ready output register for the FIFO read side. A word is
// loaded whenever the controller fetches; it is held until the consumer takes it.
module fifo_out_reg
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_i,
    input  logic [DATA_SIZE-1:0] fetch_data_i,
    input  logic                 dready_i,
    output logic [DATA_SIZE-1:0] dout_o,
    output logic                 dvalid_o,
    output logic                 accept_o
);

    out_state_t           state_q;
    logic                 dvalid_q;
    logic [DATA_SIZE-1:0] dout_q;

    // The register can take a new word when it is empty or being drained this cycle.
    assign accept_o = !dvalid_q || dready_i;
    assign dout_o   = dout_q;
    assign dvalid_o = dvalid_q;

    // Two-state holding register; dout only changes on a fetch, so it is stable while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= OUT_EMPTY;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (fetch_i) begin
                        state_q  <= OUT_FULL;
                        dvalid_q <= 1'b1;
                        dout_q   <= fetch_data_i;
                    end
                end
                OUT_FULL: begin
                    if (dready_i) begin
                        if (fetch_i) begin
                            dout_q <= fetch_data_i;
                        end else begin
                            state_q  <= OUT_EMPTY;
                            dvalid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= OUT_EMPTY;
                    dvalid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO (rclk domain). Owns the binary and
// Gray read pointers, derives empty from the synchronized write pointer and
// feeds the output register. Define FIFO_RD_LEVEL_EN to add the rlevel output.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
`ifdef FIFO_RD_LEVEL_EN
    output logic [ADDR_SIZE:0]   rlevel,
`endif
    output logic                 rempty,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dvalid,
    input  logic                 dready
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] rbin_q;
    logic [PW-1:0] rbin_d;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rgray_d;
    logic          rempty_q;
    logic          fetch;
    logic          accept;

    // A word leaves memory only when memory holds one and the output register can take it.
    assign fetch   = !rempty_q && accept;
    assign rbin_d  = rbin_q + PW'(fetch);
    assign rgray_d = PW'(bin2gray(PTR_W_MAX'(rbin_d)));

    assign raddr  = rbin_q[ADDR_SIZE-1:0];
    assign rptr   = rptr_q;
    assign rempty = rempty_q;

    // Pointer and empty-flag registers; empty compares the next Gray pointer so it is never late.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rgray_d;
            rempty_q <= (rgray_d == rq2_wptr);
        end
    end

    fifo_out_reg #(
        .DATA_SIZE (DATA_SIZE)
    ) u_out_reg (
        .clk_i        (rclk),
        .rst_i        (rrst),
        .fetch_i      (fetch),
        .fetch_data_i (rdata),
        .dready_i     (dready),
        .dout_o       (dout),
        .dvalid_o     (dvalid),
        .accept_o     (accept)
    );

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] wbin;
    logic          dvalid_d;
    logic [PW-1:0] rlevel_d;
    logic [PW-1:0] rlevel_q;

    assign wbin     = PW'(gray2bin(PTR_W_MAX'(rq2_wptr)));
    assign dvalid_d = fetch || (dvalid && !dready);
    assign rlevel_d = wbin - rbin_d + PW'(dvalid_d);
    assign rlevel   = rlevel_q;

    // Occupancy counts words still in memory plus the one held in the output register.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel_q <= '0;
        end else begin
            rlevel_q <= rlevel_d;
        end
    end
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the async FIFO, running entirely in the read clock domain.
- Owns the read pointer (binary and Gray) and computes empty against the synchronized write pointer.
- Drives the read address into the dual-port memory and captures the memory's combinational read data into a one-entry output register.
- Presents that register to the consumer through a valid/ready handshake.

Parameters:
- DATA_SIZE, 32, word width; must match the memory.
- ADDR_SIZE, 6, memory address width; depth = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits.

Ports:
- rclk  input  1  read-domain clock; all state changes on its rising edge.
- rrst  input  1  synchronous, active-high reset, sampled on rclk.
- rq2_wptr  input  ADDR_SIZE+1  write pointer, Gray coded, already two-flop synchronized into rclk.
- rdata  input  DATA_SIZE  combinational read data from memory at raddr.
- raddr  output  ADDR_SIZE  memory read address = rbin[ADDR_SIZE-1:0].
- rptr  output  ADDR_SIZE+1  registered Gray read pointer, sent to the write-side synchronizer.
- rempty  output  1  registered memory-empty flag.
- dout  output  DATA_SIZE  output register data.
- dvalid  output  1  dout holds an unconsumed word.
- dready  input  1  consumer accepts dout this cycle when dvalid=1.

Behaviour:
Reset:
- rrst=1 at an edge forces rbin=0, rptr=0, rempty=1, dvalid=0, dout=0.
- Reset mid-stream discards the buffered word and any unread memory contents.
- The write side is reset in the same system reset event; this block does not track it.

Fetch:
- fetch = !rempty && (!dvalid || dready).
- rbinnext = rbin + fetch, wrapping modulo 2^(ADDR_SIZE+1).
- rgraynext = (rbinnext>>1) ^ rbinnext.
- rbin <= rbinnext and rptr <= rgraynext every edge.
- rempty <= (rgraynext == rq2_wptr).

Output register (two states: EMPTY dvalid=0, FULL dvalid=1):
- EMPTY & fetch -> FULL, dout <= rdata.
- FULL & dready & fetch -> FULL, dout <= rdata. Back-to-back transfer with no bubble gives 1 word/cycle sustained.
- FULL & dready & !fetch -> EMPTY; dout holds its old value.
- FULL & !dready -> FULL; dout and dvalid stable. No fetch occurs, and dout must not change while dvalid=1 && !dready.

Latency:
- A new rq2_wptr value seen at edge N gives rempty=0 after edge N+1 and dvalid=1 after edge N+2.

Boundaries:
- Pointer wrap is handled by the MSB in Gray/binary; raddr wraps naturally.
- rempty is never read as 0 when the memory is empty. Read underflow is impossible by construction.
- dready while dvalid=0 has no effect.
- Combinational paths: dready only influences fetch and state; no output depends combinationally on dready.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN.
- When defined, adds output rlevel [ADDR_SIZE:0], registered.
- rlevel = gray2bin(rq2_wptr) - rbinnext (modulo 2^(ADDR_SIZE+1)) + (dvalid_next ? 1 : 0), counting words in memory plus the output register.
- rlevel resets to 0.
- When not defined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_SIZE/ADDR_SIZE constants;
  - bin2gray and gray2bin functions, used by both the read and write controllers.
- One natural sub-module: fifo_out_reg, the one-entry valid/ready output register (inputs fetch data/strobe, dready; outputs dout/dvalid/accept).

Test Plan (ADDR_SIZE=2, DATA_SIZE=8):
1. Reset with rq2_wptr=0 -> rempty=1, dvalid=0, raddr=0, rptr=0. Hold 5 cycles -> no change.
2. Preload mem[0..2]=0xA0,0xA1,0xA2, step rq2_wptr to Gray(3)=3'b010, dready=1 -> dvalid rises 2 cycles later. dout sequence 0xA0,0xA1,0xA2 on consecutive cycles, then dvalid=0. rptr ends at 3'b010, rempty=1.
3. Fill 4 words (rq2_wptr=Gray(4)=3'b110), dready=0 -> one word in dout (0xA0), rbin=1, dout stable for 10 cycles. Then dready=1 -> remaining 3 words at one per cycle.
4. Wrap: run 10 words through, pointers passing 7->0 -> data order preserved. rptr follows Gray 3'b100 -> 3'b000, with no false rempty=0.
5. Assert rrst while dvalid=1 and 2 words remain -> next cycle dvalid=0, rempty=1, rptr=0, dout=0.
6. With FIFO_RD_LEVEL_EN defined, scenario 3 -> rlevel=4 after the first fetch settles, then decrements by 1 per accepted word to 0.
